// File: rtl/brainhack_core.sv
// brainhack_core: single-cycle Brainfuck-style core driving external tape/stack RAMs and program ROM.
// Optional feature: define BRAINHACK_HALT_EN to make opcode 111 a sticky halt (cleared only by reset).
module brainhack_core #(
  parameter int TAPE_ADDR_WIDTH   = 8,
  parameter int TAPE_DATA_WIDTH   = 8,
  parameter int PRGMEM_ADDR_WIDTH = 8,
  parameter int STACK_ADDR_WIDTH  = 4,
  parameter int INSTR_WIDTH       = 3
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [TAPE_DATA_WIDTH-1:0]   i_tape_data,
  input  logic [INSTR_WIDTH-1:0]       i_prgmem_data,
  input  logic [PRGMEM_ADDR_WIDTH-1:0] i_stack_data,
  output logic                         o_tape_in,
  output logic [TAPE_ADDR_WIDTH-1:0]   o_tape_addr,
  output logic [TAPE_DATA_WIDTH-1:0]   o_tape_data,
  output logic [PRGMEM_ADDR_WIDTH-1:0] o_prgmem_addr,
  output logic                         o_stack_in,
  output logic [STACK_ADDR_WIDTH-1:0]  o_stack_addr,
  output logic [PRGMEM_ADDR_WIDTH-1:0] o_stack_data
);

  typedef enum logic [2:0] {
    OP_INC   = 3'b000,
    OP_DEC   = 3'b001,
    OP_RIGHT = 3'b010,
    OP_LEFT  = 3'b011,
    OP_OPEN  = 3'b100,
    OP_CLOSE = 3'b101,
    OP_NOP   = 3'b110,
    OP_HALT  = 3'b111
  } opcode_t;

  // SKIP flag and HALTED are folded into one mode register; they are never set together.
  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_SKIP,
    MODE_HALT
  } mode_t;

  logic [PRGMEM_ADDR_WIDTH-1:0] pc;
  logic [TAPE_ADDR_WIDTH-1:0]   ptr;
  logic [STACK_ADDR_WIDTH-1:0]  sp;
  logic [STACK_ADDR_WIDTH-1:0]  skip_sp;
  mode_t                        mode;

  opcode_t                      op;
  logic                         zero;
  logic [PRGMEM_ADDR_WIDTH-1:0] pc_inc;

  assign op     = opcode_t'(i_prgmem_data[2:0]);
  assign zero   = (i_tape_data == '0);
  assign pc_inc = pc + 1'b1;

  assign o_tape_addr   = ptr;
  assign o_prgmem_addr = pc;
  assign o_stack_data  = pc_inc;

  always_comb begin
    o_tape_in    = 1'b0;
    o_stack_in   = 1'b0;
    o_tape_data  = i_tape_data + 1'b1;
    o_stack_addr = sp;
    if (op == OP_DEC)
      o_tape_data = i_tape_data - 1'b1;
    if (op == OP_CLOSE)
      o_stack_addr = sp - 1'b1;
    unique case (mode)
      MODE_RUN: begin
        o_tape_in  = (op == OP_INC) || (op == OP_DEC);
        o_stack_in = (op == OP_OPEN) && !zero;
      end
      // Nested '[' inside a skipped loop still bumps SP, so the slot is written with don't-care data.
      MODE_SKIP: o_stack_in = (op == OP_OPEN);
      default: ;
    endcase
    if (!reset_n) begin
      o_tape_in  = 1'b0;
      o_stack_in = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc      <= '0;
      ptr     <= '0;
      sp      <= '0;
      skip_sp <= '0;
      mode    <= MODE_RUN;
    end else begin
      unique case (mode)
        MODE_RUN: begin
          pc <= pc_inc;
          unique case (op)
            OP_RIGHT: ptr <= ptr + 1'b1;
            OP_LEFT:  ptr <= ptr - 1'b1;
            OP_OPEN: begin
              if (zero) begin
                mode    <= MODE_SKIP;
                skip_sp <= sp;
              end else begin
                sp <= sp + 1'b1;
              end
            end
            OP_CLOSE: begin
              if (zero)
                sp <= sp - 1'b1;
              else
                pc <= i_stack_data;
            end
            OP_HALT: begin
`ifdef BRAINHACK_HALT_EN
              pc   <= pc;
              mode <= MODE_HALT;
`endif
            end
            default: ;
          endcase
        end
        MODE_SKIP: begin
          pc <= pc_inc;
          if (op == OP_OPEN) begin
            sp <= sp + 1'b1;
          end else if (op == OP_CLOSE) begin
            if (sp == skip_sp)
              mode <= MODE_RUN;
            else
              sp <= sp - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_brainhack_core.sv
// Self-checking bench for brainhack_core: directed program table, hand sequences, and random
// programs checked cycle-by-cycle against a queue-based Brainfuck interpreter model.
module tb_brainhack_core;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n;
  logic [7:0] tape_rd;
  logic [2:0] rom_rd;
  logic [7:0] stack_rd;
  logic       tape_in;
  logic [7:0] tape_addr;
  logic [7:0] tape_wd;
  logic [7:0] prg_addr;
  logic       stack_in;
  logic [3:0] stack_addr;
  logic [7:0] stack_wd;

  logic [7:0] tape_mem  [256];
  logic [7:0] stack_mem [16];
  logic [2:0] rom       [256];
  logic       mem_clear;

  assign tape_rd  = tape_mem[tape_addr];
  assign stack_rd = stack_mem[stack_addr];
  assign rom_rd   = rom[prg_addr];

  always @(posedge clock) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) tape_mem[i] <= '0;
      for (int i = 0; i < 16; i++) stack_mem[i] <= '0;
    end else begin
      if (tape_in) tape_mem[tape_addr] <= tape_wd;
      if (stack_in) stack_mem[stack_addr] <= stack_wd;
    end
  end

  brainhack_core #(
    .TAPE_ADDR_WIDTH(8),
    .TAPE_DATA_WIDTH(8),
    .PRGMEM_ADDR_WIDTH(8),
    .STACK_ADDR_WIDTH(4),
    .INSTR_WIDTH(3)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_tape_data  (tape_rd),
    .i_prgmem_data(rom_rd),
    .i_stack_data (stack_rd),
    .o_tape_in    (tape_in),
    .o_tape_addr  (tape_addr),
    .o_tape_data  (tape_wd),
    .o_prgmem_addr(prg_addr),
    .o_stack_in   (stack_in),
    .o_stack_addr (stack_addr),
    .o_stack_data (stack_wd)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_prog(input string s);
    for (int i = 0; i < 256; i++) rom[i] = 3'b110;
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "+": rom[i] = 3'b000;
        "-": rom[i] = 3'b001;
        ">": rom[i] = 3'b010;
        "<": rom[i] = 3'b011;
        "[": rom[i] = 3'b100;
        "]": rom[i] = 3'b101;
        "h": rom[i] = 3'b111;
        default: rom[i] = 3'b110;
      endcase
    end
  endtask

  task automatic reset_dut();
    reset_n   = 1'b0;
    mem_clear = 1'b1;
    tick();
    mem_clear = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  // Reference interpreter: real stack as a queue, skip mode as a nesting depth counter.
  int m_pc, m_ptr, m_depth;
  bit m_skip, m_halt;
  int m_tape [256];
  int q [$];

  task automatic model_reset();
    m_pc = 0; m_ptr = 0; m_depth = 0; m_skip = 0; m_halt = 0;
    q.delete();
    for (int i = 0; i < 256; i++) m_tape[i] = 0;
  endtask

  function automatic int model_sp();
    return (q.size() + m_depth) % 16;
  endfunction

  task automatic model_step();
    int op;
    op = int'(rom[m_pc]);
    if (m_halt) return;
    if (m_skip) begin
      if (op == 4) m_depth++;
      else if (op == 5) begin
        if (m_depth == 0) m_skip = 0;
        else m_depth--;
      end
      m_pc = (m_pc + 1) % 256;
      return;
    end
    case (op)
      0: m_tape[m_ptr] = (m_tape[m_ptr] + 1) % 256;
      1: m_tape[m_ptr] = (m_tape[m_ptr] + 255) % 256;
      2: m_ptr = (m_ptr + 1) % 256;
      3: m_ptr = (m_ptr + 255) % 256;
      4: begin
        if (m_tape[m_ptr] != 0) q.push_back((m_pc + 1) % 256);
        else begin m_skip = 1; m_depth = 0; end
      end
      5: begin
        if (m_tape[m_ptr] != 0) begin
          m_pc = q[$];
          return;
        end
        void'(q.pop_back());
      end
      7: begin
`ifdef BRAINHACK_HALT_EN
        m_halt = 1;
        return;
`endif
      end
      default: ;
    endcase
    m_pc = (m_pc + 1) % 256;
  endtask

  typedef struct {
    string name;
    string prog;
    int    cycles;
    int    pc;
    int    ptr;
    int    sp;
    int    t0;
    int    t1;
    int    t255;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int halt_pc;
    int depth, r, exp_sa, first_bad, bad_before;
    logic [2:0] g;

`ifdef BRAINHACK_HALT_EN
    halt_pc = 1;
`else
    halt_pc = 5;
`endif
    reset_n   = 1'b0;
    mem_clear = 1'b0;

    vecs[0] = '{"plus3",       "+++",       3,   3,   0,   0,  3, 0, 0};
    vecs[1] = '{"left_dec",    "<-",        2,   2,   255, 0,  0, 0, 255};
    vecs[2] = '{"clear_loop",  "++[-]",     7,   5,   0,   0,  0, 0, 0};
    vecs[3] = '{"skip_nested", "[[+]+]>+",  8,   8,   1,   0,  0, 1, 0};
    vecs[4] = '{"move_loop",   "+++[->+<]", 19,  9,   0,   0,  0, 3, 0};
    vecs[5] = '{"halt",        "+h",        5,   halt_pc, 0, 0, 1, 0, 0};
    vecs[6] = '{"pc_wrap",     "",          256, 0,   0,   0,  0, 0, 0};
    vecs[7] = '{"underflow",   "]",         1,   1,   0,   15, 0, 0, 0};

    for (int v = 0; v < 8; v++) begin
      load_prog(vecs[v].prog);
      reset_dut();
      check({vecs[v].name, "_rst_pc"}, int'(prg_addr), 0);
      for (int c = 0; c < vecs[v].cycles; c++) tick();
      check({vecs[v].name, "_pc"},    int'(prg_addr),    vecs[v].pc);
      check({vecs[v].name, "_ptr"},   int'(tape_addr),   vecs[v].ptr);
      check({vecs[v].name, "_sp"},    int'(stack_addr),  vecs[v].sp);
      check({vecs[v].name, "_t0"},    int'(tape_mem[0]), vecs[v].t0);
      check({vecs[v].name, "_t1"},    int'(tape_mem[1]), vecs[v].t1);
      check({vecs[v].name, "_t255"},  int'(tape_mem[255]), vecs[v].t255);
    end

    // Skip mode: nested '[' raises SP and writes the stack, tape stays untouched.
    load_prog("[[+]+]>+");
    reset_dut();
    check("skip_rst_tape_in", int'(tape_in), 0);
    tick();
    check("skip_push_we", int'(stack_in), 1);
    tick();
    check("skip_sp_up", int'(stack_addr), 1);
    check("skip_no_tape_we", int'(tape_in), 0);
    tick();
    tick();
    check("skip_sp_down", int'(stack_addr), 0);
    check("skip_still_no_we", int'(tape_in), 0);

    // Reset in the middle of an infinite loop.
    load_prog("+[]");
    reset_dut();
    for (int c = 0; c < 10; c++) tick();
    check("loop_pc", int'(prg_addr), 2);
    check("loop_top_addr", int'(stack_addr), 0);
    reset_n = 1'b0;
    tick();
    check("midrst_pc", int'(prg_addr), 0);
    check("midrst_ptr", int'(tape_addr), 0);
    check("midrst_sp", int'(stack_addr), 0);
    check("midrst_tape_we", int'(tape_in), 0);
    check("midrst_tape_kept", int'(tape_mem[0]), 1);
    reset_n = 1'b1;
    tick();
    check("postrst_inc", int'(tape_mem[0]), 2);

    // Random balanced programs against the reference interpreter.
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 256; i++) rom[i] = 3'b110;
      depth = 0;
      for (int i = 0; i < 40; i++) begin
        if (depth > 0 && (40 - i) <= depth) begin
          g = 3'b101; depth--;
        end else begin
          r = int'($urandom_range(0, 11));
          case (r)
            0, 1:  g = 3'b000;
            2:     g = 3'b001;
            3, 4:  g = 3'b010;
            5:     g = 3'b011;
            6:     g = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'b110;
            7, 8:  if (depth < 3) begin g = 3'b100; depth++; end else g = 3'b000;
            default: if (depth > 0) begin g = 3'b101; depth--; end else g = 3'b001;
          endcase
        end
        rom[i] = g;
      end
      reset_dut();
      model_reset();
      bad_before = bad;
      for (int c = 0; c < 300; c++) begin
        model_step();
        tick();
        exp_sa = (rom[m_pc] == 3'b101) ? (model_sp() + 15) % 16 : model_sp();
        check("rand_pc", int'(prg_addr), m_pc);
        check("rand_ptr", int'(tape_addr), m_ptr);
        check("rand_stack_addr", int'(stack_addr), exp_sa);
        if (bad != bad_before) break;
      end
      first_bad = -1;
      for (int i = 0; i < 256; i++)
        if (first_bad < 0 && int'(tape_mem[i]) != m_tape[i]) first_bad = i;
      check("rand_tape_first_bad_cell", first_bad, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
